// File: rtl/seven_segment_capture.sv
// Decodes scanned 7-segment drive lines back into per-digit hex values.
// Define SEG_CAPTURE_SYNC_EN to put 2-flop synchronizers on all inputs.
module seven_segment_capture #(
    parameter int NUM_DIGITS    = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    input  logic [NUM_DIGITS-1:0]   i_Digit_En,
    input  logic                    i_Segment_A,
    input  logic                    i_Segment_B,
    input  logic                    i_Segment_C,
    input  logic                    i_Segment_D,
    input  logic                    i_Segment_E,
    input  logic                    i_Segment_F,
    input  logic                    i_Segment_G,
    input  logic                    i_Err_Clr,
    output logic [4*NUM_DIGITS-1:0] o_Binary_Num,
    output logic [NUM_DIGITS-1:0]   o_Digit_Valid,
    output logic                    o_Update,
    output logic                    o_Error
);

    localparam int SW = NUM_DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_HELD
    } state_t;

    logic [SW-1:0] raw;
    logic [SW-1:0] in_s;
    logic [SW-1:0] samp;

    assign raw = {i_Digit_En, i_Segment_A, i_Segment_B, i_Segment_C,
                  i_Segment_D, i_Segment_E, i_Segment_F, i_Segment_G};

`ifdef SEG_CAPTURE_SYNC_EN
    logic [SW-1:0] sync1;
    logic [SW-1:0] sync2;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign in_s = sync2;
`else
    assign in_s = raw;
`endif

    state_t  state;
    logic [CW-1:0] cnt;

    logic [NUM_DIGITS-1:0]   samp_en;
    logic [6:0]              samp_pat;
    logic                    changed;
    logic                    en_zero;
    logic                    capture;
    logic [CW-1:0]           cnt_inc;
    logic [4:0]              dec;
    logic [4*NUM_DIGITS-1:0] nxt_num;
    logic [NUM_DIGITS-1:0]   nxt_valid;
    logic                    cap_err;

    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h7E:   r = 5'h10;
            7'h30:   r = 5'h11;
            7'h6D:   r = 5'h12;
            7'h79:   r = 5'h13;
            7'h33:   r = 5'h14;
            7'h5B:   r = 5'h15;
            7'h5F:   r = 5'h16;
            7'h70:   r = 5'h17;
            7'h7F:   r = 5'h18;
            7'h7B:   r = 5'h19;
            7'h77:   r = 5'h1A;
            7'h1F:   r = 5'h1B;
            7'h4E:   r = 5'h1C;
            7'h3D:   r = 5'h1D;
            7'h4F:   r = 5'h1E;
            7'h47:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    assign samp_en  = samp[SW-1:7];
    assign samp_pat = samp[6:0];
    assign changed  = (in_s != samp);
    assign en_zero  = (in_s[SW-1:7] == '0);
    assign capture  = (state == S_SETTLE) &&
                      (cnt == CW'(STABLE_CYCLES - 1));
    assign cnt_inc  = (cnt == CW'(STABLE_CYCLES)) ? cnt : cnt + 1'b1;
    assign dec      = decode(samp_pat);

    // The sample reg holds the pattern that stayed stable, so capture uses it.
    always_comb begin
        nxt_num   = o_Binary_Num;
        nxt_valid = o_Digit_Valid;
        cap_err   = 1'b0;
        if (!$onehot(samp_en)) begin
            cap_err = 1'b1;
        end else begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (samp_en[k]) begin
                    if (dec[4]) begin
                        nxt_num[4*k +: 4] = dec[3:0];
                        nxt_valid[k]      = 1'b1;
                    end else begin
                        nxt_valid[k] = 1'b0;
                        cap_err      = (samp_pat != 7'h00);
                    end
                end
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            samp          <= '0;
            o_Binary_Num  <= '0;
            o_Digit_Valid <= '0;
            o_Update      <= 1'b0;
            o_Error       <= 1'b0;
        end else begin
            samp     <= in_s;
            o_Update <= 1'b0;
            if (capture) begin
                o_Binary_Num  <= nxt_num;
                o_Digit_Valid <= nxt_valid;
                o_Update      <= (nxt_num != o_Binary_Num) ||
                                 (nxt_valid != o_Digit_Valid);
            end
            if (capture && cap_err)
                o_Error <= 1'b1;
            else if (i_Err_Clr)
                o_Error <= 1'b0;

            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!en_zero)
                        state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (en_zero) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (changed) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt_inc;
                        if (capture)
                            state <= S_HELD;
                    end
                end
                S_HELD: begin
                    if (en_zero) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (changed) begin
                        state <= S_SETTLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed self-checking bench for seven_segment_capture (2 digits, 4 samples).
module tb_seven_segment_capture;

`ifdef SEG_CAPTURE_SYNC_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] en  = 2'b00;
    logic [6:0] pat = 7'h00;
    logic       clr = 1'b0;
    logic [7:0] num;
    logic [1:0] valid;
    logic       upd;
    logic       err;

    int vectors    = 0;
    int miscompares = 0;
    int upd_cnt    = 0;

    always #5 clk = ~clk;

    seven_segment_capture #(
        .NUM_DIGITS(2),
        .STABLE_CYCLES(4)
    ) dut (
        .i_Clk(clk),
        .i_Reset(rst),
        .i_Digit_En(en),
        .i_Segment_A(pat[6]),
        .i_Segment_B(pat[5]),
        .i_Segment_C(pat[4]),
        .i_Segment_D(pat[3]),
        .i_Segment_E(pat[2]),
        .i_Segment_F(pat[1]),
        .i_Segment_G(pat[0]),
        .i_Err_Clr(clr),
        .o_Binary_Num(num),
        .o_Digit_Valid(valid),
        .o_Update(upd),
        .o_Error(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (upd === 1'b1) upd_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive(input logic [1:0] e, input logic [6:0] p);
        en  = e;
        pat = p;
    endtask

    initial begin
        // reset state
        tick();
        chk("rst_num", num, 8'h00);
        chk("rst_valid", valid, 2'b00);
        chk("rst_upd", upd, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;

        // 6D for 3 edges, then 79 held: 2 must never be captured
        upd_cnt = 0;
        drive(2'b01, 7'h6D);
        ticks(3);
        drive(2'b01, 7'h79);
        ticks(LAT);
        chk("t3_early_num", num, 8'h00);
        chk("t3_early_upd", upd_cnt, 0);
        tick();
        chk("t3_num", num, 8'h03);
        chk("t3_valid", valid, 2'b01);
        chk("t3_upd", upd, 1'b1);

        // 6D held: capture after LAT stable edges, one pulse only
        drive(2'b01, 7'h6D);
        ticks(LAT);
        chk("t2_before", num, 8'h03);
        chk("t2_before_upd", upd, 1'b0);
        tick();
        chk("t2_num", num, 8'h02);
        chk("t2_valid", valid, 2'b01);
        chk("t2_upd", upd, 1'b1);
        upd_cnt = 0;
        ticks(8);
        chk("t2_no_more_upd", upd_cnt, 0);

        // alternate digits
        upd_cnt = 0;
        drive(2'b01, 7'h4E);
        ticks(LAT + 4);
        drive(2'b10, 7'h3D);
        ticks(LAT + 4);
        chk("t4_pass1_num", num, 8'hDC);
        chk("t4_pass1_valid", valid, 2'b11);
        chk("t4_pass1_upd", upd_cnt, 2);
        upd_cnt = 0;
        drive(2'b01, 7'h4E);
        ticks(LAT + 4);
        drive(2'b10, 7'h3D);
        ticks(LAT + 4);
        chk("t4_pass2_num", num, 8'hDC);
        chk("t4_pass2_upd", upd_cnt, 0);

        // async reset mid-settle
        drive(2'b01, 7'h7B);
        ticks(2);
        #2 rst = 1'b1;
        #1;
        chk("t1_num", num, 8'h00);
        chk("t1_valid", valid, 2'b00);
        @(posedge clk);
        #1 rst = 1'b0;
        ticks(LAT);
        chk("t1_nocap", valid, 2'b00);
        tick();
        chk("t1_cap_num", num, 8'h09);
        chk("t1_cap_valid", valid, 2'b01);
        chk("t1_cap_upd", upd, 1'b1);

        // blank pattern keeps digit value, clears valid, no error
        drive(2'b01, 7'h5B);
        ticks(LAT + 1);
        chk("t6_num5", num, 8'h05);
        drive(2'b01, 7'h00);
        ticks(LAT);
        tick();
        chk("t6_upd", upd, 1'b1);
        chk("t6_valid", valid, 2'b00);
        chk("t6_num", num, 8'h05);
        chk("t6_err", err, 1'b0);

        // illegal pattern, clear, non-one-hot enable
        drive(2'b10, 7'h01);
        ticks(LAT + 1);
        chk("t5_valid", valid, 2'b00);
        chk("t5_err", err, 1'b1);
        ticks(3);
        chk("t5_sticky", err, 1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t5_clr", err, 1'b0);
        drive(2'b11, 7'h7E);
        ticks(LAT + 1);
        chk("t5_multi_err", err, 1'b1);
        chk("t5_multi_num", num, 8'h05);
        chk("t5_multi_valid", valid, 2'b00);

        // clear coinciding with a fresh error: set wins
        drive(2'b10, 7'h01);
        ticks(LAT);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t5_set_wins", err, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
